// File: rtl/usbdev_wb_arbiter_pkg.sv
// rtl/usbdev_wb_arbiter_pkg.sv - shared Wishbone bus widths, arbiter state encoding and watchdog sizing
package usbdev_wb_arbiter_pkg;

   localparam int ADR_W_DEF = 14;
   localparam int DAT_W_DEF = 32;
   localparam int SEL_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_ABORT = 2'd3
   } arb_state_e;

   // A disabled watchdog (TIMEOUT=0) still gets a 1-bit counter so the vector stays legal.
   function automatic int wdog_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/usbdev_wb_arbiter_watchdog.sv
// rtl/usbdev_wb_arbiter_watchdog.sv - saturating stall counter that flags a strobe left unacknowledged for TIMEOUT cycles
module usbdev_wb_arbiter_watchdog
   import usbdev_wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic stb,
   input  logic ack,
   output logic expire
);

   localparam int W = wdog_width(TIMEOUT);
   localparam logic [W-1:0] WDOG_MAX = '1;
   localparam logic [W-1:0] WDOG_TMO = W'(TIMEOUT);

   logic [W-1:0] wdog_q;
   logic [W-1:0] wdog_d;

   always_comb begin
      wdog_d = wdog_q;
      if (ack || !stb) begin
         wdog_d = '0;
      end else if (wdog_q != WDOG_MAX) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   // An ACK landing on the limit cycle completes the beat instead of aborting it.
   assign expire = (TIMEOUT != 0) && stb && !ack && (wdog_q == WDOG_TMO);

endmodule

// File: rtl/usbdev_wb_arbiter.sv
// rtl/usbdev_wb_arbiter.sv - two-master classic Wishbone arbiter with CYC lock, round-robin and stall abort
module usbdev_wb_arbiter
   import usbdev_wb_arbiter_pkg::*;
#(
   parameter int ADR_W      = ADR_W_DEF,
   parameter int DAT_W      = DAT_W_DEF,
   parameter int SEL_W      = SEL_W_DEF,
   parameter int TIMEOUT    = 255,
   parameter int FIXED_PRIO = 0
) (
   input  logic             ctrlCd_clk,
   input  logic             ctrlCd_reset,
   input  logic             m0_CYC,
   input  logic             m0_STB,
   input  logic             m0_WE,
   input  logic [ADR_W-1:0] m0_ADR,
   input  logic [SEL_W-1:0] m0_SEL,
   input  logic [DAT_W-1:0] m0_DAT_MOSI,
   output logic [DAT_W-1:0] m0_DAT_MISO,
   output logic             m0_ACK,
   output logic             m0_ERR,
   input  logic             m1_CYC,
   input  logic             m1_STB,
   input  logic             m1_WE,
   input  logic [ADR_W-1:0] m1_ADR,
   input  logic [SEL_W-1:0] m1_SEL,
   input  logic [DAT_W-1:0] m1_DAT_MOSI,
   output logic [DAT_W-1:0] m1_DAT_MISO,
   output logic             m1_ACK,
   output logic             m1_ERR,
   output logic             s_CYC,
   output logic             s_STB,
   output logic             s_WE,
   output logic [ADR_W-1:0] s_ADR,
   output logic [SEL_W-1:0] s_SEL,
   output logic [DAT_W-1:0] s_DAT_MOSI,
   input  logic [DAT_W-1:0] s_DAT_MISO,
   input  logic             s_ACK,
   output logic [1:0]       grant
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       owner_q, owner_d;
   logic       err_first_q, err_first_d;
   logic       wdog_expire;

   usbdev_wb_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk    (ctrlCd_clk),
      .reset  (ctrlCd_reset),
      .stb    (s_STB),
      .ack    (s_ACK),
      .expire (wdog_expire)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      err_first_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m0_CYC && m1_CYC) begin
               state_d = ((FIXED_PRIO != 0) || last_q) ? ST_OWN0 : ST_OWN1;
            end else if (m0_CYC) begin
               state_d = ST_OWN0;
            end else if (m1_CYC) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!m0_CYC) begin
               state_d = ST_IDLE;
               last_d  = 1'b0;
            end else if (wdog_expire) begin
               state_d     = ST_ABORT;
               owner_d     = 1'b0;
               err_first_d = 1'b1;
            end
         end
         ST_OWN1: begin
            if (!m1_CYC) begin
               state_d = ST_IDLE;
               last_d  = 1'b1;
            end else if (wdog_expire) begin
               state_d     = ST_ABORT;
               owner_d     = 1'b1;
               err_first_d = 1'b1;
            end
         end
         ST_ABORT: begin
            if (!(owner_q ? m1_CYC : m0_CYC)) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ctrlCd_clk) begin
      if (ctrlCd_reset) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         err_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         err_first_q <= err_first_d;
      end
   end

   // Reset also silences the bus in the cycle it is sampled, so an in-flight beat never terminates.
   always_comb begin
      s_CYC       = 1'b0;
      s_STB       = 1'b0;
      s_WE        = 1'b0;
      s_ADR       = '0;
      s_SEL       = '0;
      s_DAT_MOSI  = '0;
      m0_ACK      = 1'b0;
      m0_ERR      = 1'b0;
      m0_DAT_MISO = '0;
      m1_ACK      = 1'b0;
      m1_ERR      = 1'b0;
      m1_DAT_MISO = '0;
      grant       = 2'b00;
      if (!ctrlCd_reset) begin
         case (state_q)
            ST_OWN0: begin
               s_CYC       = m0_CYC;
               s_STB       = m0_STB;
               s_WE        = m0_WE;
               s_ADR       = m0_ADR;
               s_SEL       = m0_SEL;
               s_DAT_MOSI  = m0_DAT_MOSI;
               m0_ACK      = s_ACK && m0_CYC;
               m0_DAT_MISO = s_DAT_MISO;
               grant       = 2'b01;
            end
            ST_OWN1: begin
               s_CYC       = m1_CYC;
               s_STB       = m1_STB;
               s_WE        = m1_WE;
               s_ADR       = m1_ADR;
               s_SEL       = m1_SEL;
               s_DAT_MOSI  = m1_DAT_MOSI;
               m1_ACK      = s_ACK && m1_CYC;
               m1_DAT_MISO = s_DAT_MISO;
               grant       = 2'b10;
            end
            ST_ABORT: begin
               m0_ERR = err_first_q && !owner_q;
               m1_ERR = err_first_q && owner_q;
               grant  = owner_q ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_usbdev_wb_arbiter.sv
// tb/tb_usbdev_wb_arbiter.sv - bench for usbdev_wb_arbiter: round-robin, fixed-priority and no-watchdog instances
module tb_usbdev_wb_arbiter;
   import usbdev_wb_arbiter_pkg::*;

   localparam int NI    = 3;
   localparam int NEVER = 1_000_000;

   typedef struct {
      logic [13:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [31:0] rdat;
   } beat_t;

   typedef struct {
      logic       req0;
      logic       req1;
      logic [1:0] g_rr;
      logic [1:0] g_fp;
   } arb_vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mcyc [2][NI];
   logic        mstb [2][NI];
   logic        mwe  [2][NI];
   logic [13:0] madr [2][NI];
   logic [3:0]  msel [2][NI];
   logic [31:0] mmosi[2][NI];
   logic [31:0] mmiso[2][NI];
   logic        mack [2][NI];
   logic        merr [2][NI];
   logic        s_cyc[NI], s_stb[NI], s_we[NI], s_ack[NI];
   logic [13:0] s_adr[NI];
   logic [3:0]  s_sel[NI];
   logic [31:0] s_mosi[NI], s_miso[NI];
   logic [1:0]  grant[NI];
   int          scnt[NI];
   int          slv_wait[NI];
   int          ack_seen[2];
   int          total = 0;
   int          bad   = 0;
   beat_t       q0[$];
   beat_t       q1[$];

   always #5 clk = ~clk;

   // Instance 0: round-robin, TIMEOUT=8; 1: fixed priority; 2: watchdog disabled.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      usbdev_wb_arbiter #(.TIMEOUT(g == 2 ? 0 : 8), .FIXED_PRIO(g == 1 ? 1 : 0)) u_dut (
         .ctrlCd_clk(clk), .ctrlCd_reset(rst),
         .m0_CYC(mcyc[0][g]), .m0_STB(mstb[0][g]), .m0_WE(mwe[0][g]), .m0_ADR(madr[0][g]),
         .m0_SEL(msel[0][g]), .m0_DAT_MOSI(mmosi[0][g]), .m0_DAT_MISO(mmiso[0][g]),
         .m0_ACK(mack[0][g]), .m0_ERR(merr[0][g]),
         .m1_CYC(mcyc[1][g]), .m1_STB(mstb[1][g]), .m1_WE(mwe[1][g]), .m1_ADR(madr[1][g]),
         .m1_SEL(msel[1][g]), .m1_DAT_MOSI(mmosi[1][g]), .m1_DAT_MISO(mmiso[1][g]),
         .m1_ACK(mack[1][g]), .m1_ERR(merr[1][g]),
         .s_CYC(s_cyc[g]), .s_STB(s_stb[g]), .s_WE(s_we[g]), .s_ADR(s_adr[g]), .s_SEL(s_sel[g]),
         .s_DAT_MOSI(s_mosi[g]), .s_DAT_MISO(s_miso[g]), .s_ACK(s_ack[g]), .grant(grant[g])
      );
   end

   function automatic logic [31:0] slv_data(input logic [13:0] a);
      return 32'hCAFE0000 + {22'b0, a[13:4]};
   endfunction

   // Slave model: ACK after slv_wait stalled strobe cycles, same counting rule as the watchdog.
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         scnt[k] <= (s_cyc[k] && s_stb[k] && !s_ack[k]) ? scnt[k] + 1 : 0;
      end
   end

   always_comb begin
      for (int k = 0; k < NI; k++) begin
         s_ack[k]  = s_cyc[k] && s_stb[k] && (scnt[k] == slv_wait[k]);
         s_miso[k] = slv_data(s_adr[k]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_beat(input int k, input int m, input logic [13:0] adr, input logic we,
                             input logic [3:0] sel, input logic [31:0] wdat);
      beat_t e;
      mcyc[m][k]  = 1'b1;
      mstb[m][k]  = 1'b1;
      mwe[m][k]   = we;
      madr[m][k]  = adr;
      msel[m][k]  = sel;
      mmosi[m][k] = wdat;
      if (k == 0) begin
         e.adr = adr; e.we = we; e.sel = sel; e.wdat = wdat; e.rdat = slv_data(adr);
         if (m == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic wait_end(input int k, input int m, input logic exp_err, input string name,
                           output int stb_cyc);
      bit done;
      done    = 1'b0;
      stb_cyc = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (s_stb[k]) stb_cyc++;
         if (mack[m][k] || merr[m][k]) begin
            done = 1'b1;
            chk({name, "_ack"}, 32'(mack[m][k]), 32'(!exp_err));
            chk({name, "_err"}, 32'(merr[m][k]), 32'(exp_err));
            if (exp_err) chk({name, "_scyc"}, 32'(s_cyc[k]), 0);
         end
      end
      chk({name, "_done"}, 32'(done), 1);
      tick();
      mstb[m][k] = 1'b0;
   endtask

   // Scoreboard on instance 0: every ACK must match the oldest beat that master issued.
   always @(negedge clk) begin
      beat_t e;
      for (int m = 0; m < 2; m++) begin
         if (mack[m][0]) begin
            ack_seen[m]++;
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected_ack: got ack on m%0d want none", m);
            end else begin
               if (m == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk($sformatf("sb_m%0d_rdat", m), mmiso[m][0], e.rdat);
               chk($sformatf("sb_m%0d_adr", m), 32'(s_adr[0]), 32'(e.adr));
               chk($sformatf("sb_m%0d_we", m), 32'(s_we[0]), 32'(e.we));
               chk($sformatf("sb_m%0d_sel", m), 32'(s_sel[0]), 32'(e.sel));
               chk($sformatf("sb_m%0d_wdat", m), s_mosi[0], e.wdat);
               chk($sformatf("sb_m%0d_other_ack", m), 32'(mack[1-m][0]), 0);
               chk($sformatf("sb_m%0d_other_miso", m), mmiso[1-m][0], 0);
            end
         end
         if (merr[m][0]) begin
            if (m == 0 && q0.size() != 0) void'(q0.pop_front());
            if (m == 1 && q1.size() != 0) void'(q1.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      arb_vec_t   vt[7];
      logic [3:0] sels[3];
      int         n, errs, drops, acks0;
      logic [1:0] exp_g;

      vt[0] = '{1'b1, 1'b1, 2'b01, 2'b01};
      vt[1] = '{1'b1, 1'b1, 2'b10, 2'b01};
      vt[2] = '{1'b1, 1'b1, 2'b01, 2'b01};
      vt[3] = '{1'b1, 1'b1, 2'b10, 2'b01};
      vt[4] = '{1'b0, 1'b1, 2'b10, 2'b10};
      vt[5] = '{1'b1, 1'b0, 2'b01, 2'b01};
      vt[6] = '{1'b1, 1'b1, 2'b10, 2'b01};
      sels[0] = 4'hF; sels[1] = 4'h3; sels[2] = 4'h1;
      ack_seen[0] = 0;
      ack_seen[1] = 0;
      for (int k = 0; k < NI; k++) begin
         slv_wait[k] = 1;
         for (int m = 0; m < 2; m++) begin
            mcyc[m][k] = 1'b0; mstb[m][k] = 1'b0; mwe[m][k] = 1'b0;
            madr[m][k] = '0; msel[m][k] = '0; mmosi[m][k] = '0;
         end
      end

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_scyc%0d", k), 32'(s_cyc[k]), 0);
         chk($sformatf("rst_grant%0d", k), 32'(grant[k]), 0);
         chk($sformatf("rst_ackerr%0d", k), 32'({mack[0][k], merr[0][k], mack[1][k], merr[1][k]}), 0);
         chk($sformatf("rst_miso%0d", k), mmiso[0][k] | mmiso[1][k], 0);
      end

      for (int i = 0; i < 7; i++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            mcyc[0][k] = vt[i].req0;
            mcyc[1][k] = vt[i].req1;
         end
         @(negedge clk);
         chk($sformatf("arb%0d_lat_grant", i), 32'(grant[0]), 0);
         chk($sformatf("arb%0d_lat_scyc", i), 32'(s_cyc[0]), 0);
         @(negedge clk);
         for (int k = 0; k < NI; k++) begin
            exp_g = (k == 1) ? vt[i].g_fp : vt[i].g_rr;
            chk($sformatf("arb%0d_grant%0d", i, k), 32'(grant[k]), 32'(exp_g));
            chk($sformatf("arb%0d_scyc%0d", i, k), 32'(s_cyc[k]), 1);
         end
         tick();
         for (int k = 0; k < NI; k++) begin
            mcyc[0][k] = 1'b0;
            mcyc[1][k] = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("arb%0d_drop_scyc", i), 32'(s_cyc[0]), 0);
      end

      tick();
      slv_wait[0] = 2;
      start_beat(0, 0, 14'h0010, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      chk("t1_scyc_req_cycle", 32'(s_cyc[0]), 0);
      @(negedge clk);
      chk("t1_scyc_next_cycle", 32'(s_cyc[0]), 1);
      wait_end(0, 0, 1'b0, "t1", n);
      @(negedge clk);
      chk("t1_ack_one_cycle", 32'(mack[0][0]), 0);
      tick();
      mcyc[0][0] = 1'b0;

      tick();
      slv_wait[0] = 1;
      mcyc[1][0]  = 1'b1;
      tick();
      start_beat(0, 0, 14'h0200, 1'b0, 4'hF, 32'h0);
      acks0 = ack_seen[0];
      for (int j = 0; j < 3; j++) begin
         start_beat(0, 1, 14'h0100 + 14'(j), 1'b1, sels[j], 32'hA5A50000 + j);
         wait_end(0, 1, 1'b0, $sformatf("t3_w%0d", j), n);
      end
      chk("t3_m0_locked_out", ack_seen[0] - acks0, 0);
      mcyc[1][0] = 1'b0;
      @(negedge clk);
      chk("t3_drop_scyc", 32'(s_cyc[0]), 0);
      @(negedge clk);
      chk("t3_idle_gap", 32'(grant[0]), 0);
      @(negedge clk);
      chk("t3_m0_grant", 32'(grant[0]), 32'(2'b01));
      wait_end(0, 0, 1'b0, "t3_m0", n);
      mcyc[0][0] = 1'b0;

      tick();
      slv_wait[0] = NEVER;
      start_beat(0, 0, 14'h0300, 1'b1, 4'hF, 32'h12345678);
      tick();
      start_beat(0, 1, 14'h0040, 1'b0, 4'hF, 32'h0);
      wait_end(0, 0, 1'b1, "t4", n);
      chk("t4_stb_cycles", n, 9);
      @(negedge clk);
      chk("t4_err_once", 32'(merr[0][0]), 0);
      chk("t4_abort_scyc", 32'(s_cyc[0]), 0);
      chk("t4_m1_waits", 32'(mack[1][0]), 0);
      tick();
      mcyc[0][0]  = 1'b0;
      slv_wait[0] = 1;
      wait_end(0, 1, 1'b0, "t4_m1", n);
      mcyc[1][0] = 1'b0;

      tick();
      slv_wait[0] = 8;
      start_beat(0, 0, 14'h0400, 1'b0, 4'hF, 32'h0);
      wait_end(0, 0, 1'b0, "t5_edge", n);
      chk("t5_edge_stb_cycles", n, 9);
      mcyc[0][0] = 1'b0;

      tick();
      slv_wait[2] = NEVER;
      start_beat(2, 0, 14'h0500, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      errs  = 0;
      drops = 0;
      repeat (1000) begin
         @(negedge clk);
         if (merr[0][2]) errs++;
         if (!s_cyc[2]) drops++;
      end
      chk("t5_t0_no_err", errs, 0);
      chk("t5_t0_cyc_held", drops, 0);
      tick();
      mcyc[0][2] = 1'b0;
      mstb[0][2] = 1'b0;

      tick();
      slv_wait[0] = NEVER;
      start_beat(0, 1, 14'h0050, 1'b0, 4'hF, 32'h0);
      repeat (3) @(negedge clk);
      chk("t6_owned", 32'(grant[0]), 32'(2'b10));
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_scyc", 32'(s_cyc[0]), 0);
      chk("t6_rst_ackerr", 32'({mack[1][0], merr[1][0]}), 0);
      tick();
      rst = 1'b0;
      slv_wait[0] = 1;
      @(negedge clk);
      chk("t6_post_scyc", 32'(s_cyc[0]), 0);
      chk("t6_post_grant", 32'(grant[0]), 0);
      chk("t6_post_ackerr", 32'({mack[1][0], merr[1][0]}), 0);
      wait_end(0, 1, 1'b0, "t6_after", n);
      mcyc[1][0] = 1'b0;

      tick();
      chk("sb_drained", q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
